// File: rtl/segment_search_ctrl_pkg.sv
// Shared definitions for the piecewise-linear segment search controller:
// FSM encoding, default widths and the breakpoint slice helper.
package segment_search_ctrl_pkg;

  localparam int XDW_DEF     = 16;
  localparam int SEG_NUM_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // LSB position of breakpoint i inside the flattened breakpoint bus
  function automatic int bp_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/segment_search_ctrl_bp_select.sv
// Picks the lower/upper bounds of segment idx out of the flattened breakpoint bus.
module segment_search_ctrl_bp_select
  import segment_search_ctrl_pkg::*;
#(
  parameter int xDW     = XDW_DEF,
  parameter int SEG_NUM = SEG_NUM_DEF,
  parameter int IDX_W   = $clog2(SEG_NUM_DEF)
) (
  input  logic [(SEG_NUM+1)*xDW-1:0] bp_flat,
  input  logic [IDX_W-1:0]           idx,
  output logic [xDW-1:0]             bp_lo,
  output logic [xDW-1:0]             bp_hi
);

  always_comb begin
    bp_lo = bp_flat[bp_lsb(int'(idx), xDW) +: xDW];
    bp_hi = bp_flat[bp_lsb(int'(idx) + 1, xDW) +: xDW];
  end

endmodule

// File: rtl/segment_search_ctrl.sv
// Sequential segment finder: probes one breakpoint interval per cycle through an
// external half-open range comparator and hands the segment index downstream.
module segment_search_ctrl
  import segment_search_ctrl_pkg::*;
#(
  parameter int xDW     = XDW_DEF,
  parameter int SEG_NUM = SEG_NUM_DEF,
  parameter int IDX_W   = $clog2(SEG_NUM_DEF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [xDW-1:0]             xAbs,
  input  logic [(SEG_NUM+1)*xDW-1:0] bp_flat,
  output logic                       cmp_en,
  output logic [xDW-1:0]             cmp_a,
  output logic [xDW-1:0]             cmp_b,
  output logic [xDW-1:0]             cmp_xAbs,
  input  logic                       cmp_out,
  input  logic                       cmp_valid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           seg_idx,
  output logic                       out_of_range
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEG_NUM - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [xDW-1:0]   x_r;
  logic [xDW-1:0]   bp_lo, bp_hi;
  logic [xDW-1:0]   bp_top;

  assign bp_top = bp_flat[SEG_NUM*xDW +: xDW];

  segment_search_ctrl_bp_select #(
    .xDW     (xDW),
    .SEG_NUM (SEG_NUM),
    .IDX_W   (IDX_W)
  ) u_bp_select (
    .bp_flat (bp_flat),
    .idx     (idx),
    .bp_lo   (bp_lo),
    .bp_hi   (bp_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Comparator bus is forced to zero outside PROBE so idle/done cycles show clean values
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cmp_en    = 1'b0;
    out_valid = 1'b0;
    cmp_a     = '0;
    cmp_b     = '0;
    cmp_xAbs  = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = PROBE;
      end
      PROBE: begin
        cmp_en   = 1'b1;
        cmp_a    = bp_lo;
        cmp_b    = bp_hi;
        cmp_xAbs = x_r;
        if (cmp_valid && (cmp_out || idx == IDX_LAST)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      x_r          <= '0;
      seg_idx      <= '0;
      out_of_range <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r <= xAbs;
            idx <= '0;
          end
        end
        PROBE: begin
          if (cmp_valid) begin
            if (cmp_out) begin
              seg_idx      <= idx;
              out_of_range <= 1'b0;
            end else if (idx == IDX_LAST) begin
              // every interval missed: clamp toward whichever end x lies beyond
              out_of_range <= 1'b1;
              seg_idx      <= (x_r >= bp_top) ? IDX_LAST : '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_segment_search_ctrl.sv
// Randomized bench for segment_search_ctrl with an attached range comparator and
// a behavioural segment/latency reference model.
module tb_segment_search_ctrl;

  localparam int XDW = 16;
  localparam int SN  = 8;
  localparam int IW  = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [XDW-1:0]           xAbs = '0;
  logic [(SN+1)*XDW-1:0]    bp_flat;
  logic                     cmp_en;
  logic [XDW-1:0]           cmp_a, cmp_b, cmp_xAbs;
  logic                     cmp_out;
  logic                     cmp_valid = 1'b0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [IW-1:0]            seg_idx;
  logic                     out_of_range;

  logic [XDW-1:0] bp [0:SN];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    bp_flat = '0;
    for (int i = 0; i <= SN; i++) bp_flat[i*XDW +: XDW] = bp[i];
  end

  // external half-open range comparator
  assign cmp_out = cmp_en && (cmp_a <= cmp_xAbs) && (cmp_xAbs < cmp_b);

  segment_search_ctrl #(.xDW(XDW), .SEG_NUM(SN), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .xAbs         (xAbs),
    .bp_flat      (bp_flat),
    .cmp_en       (cmp_en),
    .cmp_a        (cmp_a),
    .cmp_b        (cmp_b),
    .cmp_xAbs     (cmp_xAbs),
    .cmp_out      (cmp_out),
    .cmp_valid    (cmp_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .seg_idx      (seg_idx),
    .out_of_range (out_of_range)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // segment i covers [bp[i], bp[i+1]); outside all segments clamp to the nearer end
  task automatic ref_seg(input int x, output int seg, output int oor);
    oor = 1;
    seg = (x >= int'(bp[SN])) ? SN - 1 : 0;
    for (int i = 0; i < SN; i++) begin
      if (x >= int'(bp[i]) && x < int'(bp[i+1])) begin
        seg = i;
        oor = 0;
        break;
      end
    end
  endtask

  // stall_mode: 0 = comparator always valid, 1 = random stalls, 2 = 3 stalls on first probe
  task automatic run_txn(input int x, input int stall_mode, input int hold);
    int seg, oor, probes, stalls, edges, p;
    bit done;
    ref_seg(x, seg, oor);
    probes = (oor != 0) ? SN : seg + 1;
    @(negedge clk);
    check("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    xAbs     = XDW'(x);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    xAbs     = XDW'($urandom);
    edges = 0; stalls = 0; p = 0; done = 0;
    while (!done && edges < 64) begin
      if (out_valid) begin
        done = 1;
      end else begin
        check("probe_en", cmp_en, 1);
        check("probe_ready", in_ready, 0);
        check("probe_x", cmp_xAbs, x);
        if (p < SN) begin
          check("probe_a", cmp_a, bp[p]);
          check("probe_b", cmp_b, bp[p+1]);
        end else begin
          check("probe_count", p, SN - 1);
        end
        case (stall_mode)
          1:       cmp_valid = ($urandom_range(3) != 0);
          2:       cmp_valid = (p > 0 || stalls >= 3);
          default: cmp_valid = 1'b1;
        endcase
        if (cmp_valid) p++;
        else stalls++;
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
    cmp_valid = 1'b0;
    if (!done) check("out_valid_timeout", 0, 1);
    check("latency", edges, probes + stalls);
    check("seg_idx", seg_idx, seg);
    check("out_of_range", out_of_range, oor);
    check("done_cmp_en", cmp_en, 0);
    check("done_ready", in_ready, 0);
    repeat (hold) begin
      in_valid = 1'b1;
      xAbs     = XDW'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_seg", seg_idx, seg);
      check("hold_oor", out_of_range, oor);
      check("hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
  endtask

  initial begin
    bp = '{16'd0, 16'd512, 16'd1024, 16'd2048, 16'd4096,
           16'd8192, 16'd16384, 16'd32768, 16'd65535};
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_cmp_en", cmp_en, 0);
    check("rst_cmp_a", cmp_a, 0);
    check("rst_seg", seg_idx, 0);
    check("rst_oor", out_of_range, 0);
    rst = 1'b0;

    run_txn(0, 0, 0);
    run_txn(3000, 0, 0);
    run_txn(65535, 0, 0);
    run_txn(1024, 2, 0);
    run_txn(600, 0, 5);

    // reset in the middle of the third probe
    @(negedge clk);
    in_valid = 1'b1;
    xAbs     = 16'd40000;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    cmp_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_a", cmp_a, bp[2]);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_en", cmp_en, 0);
    check("mid_rst_a", cmp_a, 0);
    check("mid_rst_b", cmp_b, 0);
    check("mid_rst_x", cmp_xAbs, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_seg", seg_idx, 0);
    check("mid_rst_oor", out_of_range, 0);
    cmp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_ready", in_ready, 1);
    end
    run_txn(100, 0, 0);

    for (int i = 0; i <= SN; i++) begin
      run_txn(int'(bp[i]), 1, int'($urandom_range(2)));
      if (bp[i] > 0) run_txn(int'(bp[i]) - 1, 1, 0);
    end
    for (int i = 0; i < 20; i++)
      run_txn(int'($urandom_range(65535)), 1, int'($urandom_range(3)));

    // second breakpoint set with bp[0] > 0 so x below the table is reachable
    bp = '{16'd100, 16'd300, 16'd700, 16'd1500, 16'd3100,
           16'd6300, 16'd12700, 16'd25500, 16'd51100};
    run_txn(50, 0, 0);
    run_txn(99, 1, 1);
    run_txn(100, 0, 0);
    run_txn(51099, 1, 0);
    run_txn(51100, 0, 0);
    run_txn(60000, 1, 0);
    for (int i = 0; i < 10; i++)
      run_txn(int'($urandom_range(65535)), 1, int'($urandom_range(2)));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
